// File: rtl/goertzel_tone_analyzer_if.sv
// Sample-in / power-out bus of the Goertzel tone analyzer.
interface goertzel_tone_analyzer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NBINS      = 4,
    parameter int COEF_WIDTH = 16,
    parameter int ACC_WIDTH  = 48,
    parameter int PWR_SHIFT  = 24
);
    localparam int TW = ACC_WIDTH - PWR_SHIFT;
    localparam int RW = 2 * TW + 2;
    localparam int BW = (NBINS > 1) ? $clog2(NBINS) : 1;

    logic                        start;
    logic [NBINS*COEF_WIDTH-1:0] coef_in;
    logic                        s_valid;
    logic [DATA_WIDTH-1:0]       s_data;
    logic                        s_ready;
    logic                        busy;
    logic                        r_valid;
    logic                        r_ready;
    logic [BW-1:0]               r_bin;
    logic [RW-1:0]               r_power;
    logic                        r_last;
    logic                        sat_flag;
    logic                        done;

    modport slave (
        input  start, coef_in, s_valid, s_data, r_ready,
        output s_ready, busy, r_valid, r_bin, r_power, r_last, sat_flag, done
    );
    modport master (
        output start, coef_in, s_valid, s_data, r_ready,
        input  s_ready, busy, r_valid, r_bin, r_power, r_last, sat_flag, done
    );
endinterface

// File: rtl/goertzel_tone_analyzer.sv
// Block Goertzel analyzer: NBINS parallel recurrences over BLOCK_LEN samples,
// then one power result per bin streamed over a valid/ready handshake.
module goertzel_lane #(
    parameter int DATA_WIDTH = 32,
    parameter int COEF_WIDTH = 16,
    parameter int COEF_FRAC  = 14,
    parameter int ACC_WIDTH  = 48
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr_i,
    input  logic                         upd_i,
    input  logic signed [COEF_WIDTH-1:0] coef_i,
    input  logic signed [DATA_WIDTH-1:0] x_i,
    output logic signed [ACC_WIDTH-1:0]  s1_o,
    output logic signed [ACC_WIDTH-1:0]  s2_o,
    output logic                         sat_o
);
    localparam int PW = ACC_WIDTH + COEF_WIDTH;
    localparam int VW = PW + 2;

    logic signed [ACC_WIDTH-1:0] s1_q, s1_d, s2_q, s2_d;
    logic signed [PW-1:0]        coef_x, s1_x, prod, p;
    logic        [VW-1:0]        v;
    logic                        ovf;

    always_comb begin
        coef_x = {{ACC_WIDTH{coef_i[COEF_WIDTH-1]}}, coef_i};
        s1_x   = {{COEF_WIDTH{s1_q[ACC_WIDTH-1]}}, s1_q};
        prod   = coef_x * s1_x;
        p      = prod >>> COEF_FRAC;
        v      = {{(VW-DATA_WIDTH){x_i[DATA_WIDTH-1]}}, x_i}
               + {{2{p[PW-1]}}, p}
               - {{(VW-ACC_WIDTH){s2_q[ACC_WIDTH-1]}}, s2_q};
        // In range only if every bit above the ACC sign bit matches it
        ovf    = !((&v[VW-1:ACC_WIDTH-1]) || !(|v[VW-1:ACC_WIDTH-1]));
        s1_d   = s1_q;
        s2_d   = s2_q;
        if (clr_i) begin
            s1_d = '0;
            s2_d = '0;
        end else if (upd_i) begin
            s2_d = s1_q;
            if (ovf)
                s1_d = v[VW-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
            else
                s1_d = v[ACC_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign s1_o  = s1_q;
    assign s2_o  = s2_q;
    assign sat_o = upd_i && ovf;
endmodule

module goertzel_tone_analyzer #(
    parameter int DATA_WIDTH = 32,
    parameter int NBINS      = 4,
    parameter int COEF_WIDTH = 16,
    parameter int COEF_FRAC  = 14,
    parameter int ACC_WIDTH  = 48,
    parameter int BLOCK_LEN  = 48000,
    parameter int PWR_SHIFT  = 24
) (
    input  logic                      clk,
    input  logic                      rst,
    goertzel_tone_analyzer_if.slave   bus
);
    localparam int TW = ACC_WIDTH - PWR_SHIFT;
    localparam int RW = 2 * TW + 2;
    localparam int PW = 2 * TW + COEF_WIDTH + 2;
    localparam int BW = (NBINS > 1) ? $clog2(NBINS) : 1;
    localparam int CW = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCUM  = 2'd1;
    localparam logic [1:0] CALC   = 2'd2;
    localparam logic [1:0] REPORT = 2'd3;

    logic [1:0]                        state_q, state_d;
    logic [CW-1:0]                     cnt_q, cnt_d;
    logic [BW-1:0]                     bin_q, bin_d, r_bin_q, r_bin_d;
    logic [NBINS-1:0][COEF_WIDTH-1:0]  coef_q, coef_d;
    logic [RW-1:0]                     r_power_q, r_power_d;
    logic                              r_valid_q, r_valid_d, r_last_q, r_last_d;
    logic                              done_q, done_d, sat_q, sat_d;

    logic                              clr, upd;
    logic [NBINS-1:0][ACC_WIDTH-1:0]   s1, s2;
    logic [NBINS-1:0]                  lane_sat;

    assign clr = (state_q == IDLE) && bus.start;
    assign upd = (state_q == ACCUM) && bus.s_valid;

    for (genvar i = 0; i < NBINS; i++) begin : g_lane
        goertzel_lane #(
            .DATA_WIDTH(DATA_WIDTH), .COEF_WIDTH(COEF_WIDTH),
            .COEF_FRAC(COEF_FRAC),   .ACC_WIDTH(ACC_WIDTH)
        ) u_lane (
            .clk(clk), .rst(rst), .clr_i(clr), .upd_i(upd),
            .coef_i(coef_q[i]), .x_i(bus.s_data),
            .s1_o(s1[i]), .s2_o(s2[i]), .sat_o(lane_sat[i])
        );
    end

    // Shared power datapath, time-multiplexed over bins by bin_q
    logic signed [TW-1:0]         a, b;
    logic signed [COEF_WIDTH-1:0] c;
    logic signed [PW-1:0]         ax, bx, cx, sq, cab_raw, cab, pw;
    logic        [RW-1:0]         p_clamp;

    always_comb begin
        a       = TW'($signed(s1[bin_q]) >>> PWR_SHIFT);
        b       = TW'($signed(s2[bin_q]) >>> PWR_SHIFT);
        c       = coef_q[bin_q];
        ax      = PW'(a);
        bx      = PW'(b);
        cx      = PW'(c);
        sq      = ax * ax + bx * bx;
        cab_raw = cx * ax * bx;
        cab     = cab_raw >>> COEF_FRAC;
        pw      = sq - cab;
        if (pw[PW-1])
            p_clamp = '0;
        else if (|pw[PW-2:RW])
            p_clamp = '1;
        else
            p_clamp = pw[RW-1:0];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bin_d     = bin_q;
        coef_d    = coef_q;
        r_valid_d = r_valid_q;
        r_power_d = r_power_q;
        r_bin_d   = r_bin_q;
        r_last_d  = r_last_q;
        done_d    = 1'b0;
        sat_d     = sat_q | (|lane_sat);
        case (state_q)
            IDLE: if (bus.start) begin
                coef_d  = bus.coef_in;
                cnt_d   = '0;
                sat_d   = 1'b0;
                state_d = ACCUM;
            end
            ACCUM: if (bus.s_valid) begin
                if (cnt_q == CW'(BLOCK_LEN - 1)) begin
                    bin_d   = '0;
                    state_d = CALC;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            CALC: begin
                r_power_d = p_clamp;
                r_bin_d   = bin_q;
                r_last_d  = (bin_q == BW'(NBINS - 1));
                r_valid_d = 1'b1;
                state_d   = REPORT;
            end
            REPORT: if (bus.r_ready) begin
                r_valid_d = 1'b0;
                r_last_d  = 1'b0;
                if (r_last_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    bin_d   = bin_q + BW'(1);
                    state_d = CALC;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bin_q     <= '0;
            coef_q    <= '0;
            r_valid_q <= 1'b0;
            r_power_q <= '0;
            r_bin_q   <= '0;
            r_last_q  <= 1'b0;
            done_q    <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bin_q     <= bin_d;
            coef_q    <= coef_d;
            r_valid_q <= r_valid_d;
            r_power_q <= r_power_d;
            r_bin_q   <= r_bin_d;
            r_last_q  <= r_last_d;
            done_q    <= done_d;
            sat_q     <= sat_d;
        end
    end

    assign bus.s_ready  = (state_q == ACCUM);
    assign bus.busy     = (state_q != IDLE);
    assign bus.r_valid  = r_valid_q;
    assign bus.r_bin    = r_bin_q;
    assign bus.r_power  = r_power_q;
    assign bus.r_last   = r_last_q;
    assign bus.sat_flag = sat_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_goertzel_tone_analyzer.sv
// Scoreboard bench for goertzel_tone_analyzer: 8-sample blocks, two bins.
module tb_goertzel_tone_analyzer;
    localparam int DW = 32, NB = 2, CWD = 16, AW = 20, PS = 0, BL = 8;
    localparam int TW = AW - PS, RW = 2 * TW + 2;
    localparam logic [NB*CWD-1:0] COEF_STD = {16'h8000, 16'h0000};
    localparam logic [NB*CWD-1:0] COEF_ALT = {16'h4000, 16'h2000};
    localparam logic [NB*CWD-1:0] COEF_SAT = {16'h3FFF, 16'h3FFF};
    localparam logic signed [DW-1:0] MAXS = 32'sh7FFF_FFFF;
    // a=b=2^19-1, coef=16383: P = a^2 + ceil(a^2/2^14)
    localparam logic [RW-1:0] P_SAT = 42'd274893635522;

    typedef struct packed { logic bin; logic [RW-1:0] pwr; logic last; } res_t;

    logic clk = 1'b0, rst = 1'b0;
    always #5 clk = ~clk;

    goertzel_tone_analyzer_if #(.DATA_WIDTH(DW), .NBINS(NB), .COEF_WIDTH(CWD),
                                .ACC_WIDTH(AW), .PWR_SHIFT(PS)) bus ();

    goertzel_tone_analyzer #(.DATA_WIDTH(DW), .NBINS(NB), .COEF_WIDTH(CWD), .COEF_FRAC(14),
                             .ACC_WIDTH(AW), .BLOCK_LEN(BL), .PWR_SHIFT(PS))
        dut (.clk(clk), .rst(rst), .bus(bus));

    res_t exp_q[$];
    int   n_chk = 0, n_fail = 0, n_done = 0;
    logic signed [DW-1:0] pat [BL] = '{32'sd1000, 32'sd0, -32'sd1000, 32'sd0,
                                       32'sd1000, 32'sd0, -32'sd1000, 32'sd0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Monitor: pops on each accepted result, checks hold-stability during stalls
    res_t held_v;
    logic held = 1'b0;
    always @(negedge clk) begin
        res_t e;
        if (!rst) begin
            held = 1'b0;
        end else begin
            if (bus.done) n_done++;
            if (bus.r_valid) begin
                if (held) begin
                    chk("stall_bin", bus.r_bin, held_v.bin);
                    chk("stall_pwr", bus.r_power, held_v.pwr);
                    chk("stall_last", bus.r_last, held_v.last);
                end
                if (bus.r_ready) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_result: got bin %0d, required none", bus.r_bin);
                    end else begin
                        e = exp_q.pop_front();
                        chk("res_bin", bus.r_bin, e.bin);
                        chk("res_pwr", bus.r_power, e.pwr);
                        chk("res_last", bus.r_last, e.last);
                    end
                    held = 1'b0;
                end else begin
                    held   = 1'b1;
                    held_v = '{bin: bus.r_bin, pwr: bus.r_power, last: bus.r_last};
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    task automatic push_std();
        exp_q.push_back('{bin: 1'b0, pwr: 42'd16000000, last: 1'b0});
        exp_q.push_back('{bin: 1'b1, pwr: 42'd0,        last: 1'b1});
    endtask

    task automatic do_start(input logic [NB*CWD-1:0] c);
        @(posedge clk); #1;
        bus.coef_in = c;
        bus.start   = 1'b1;
        @(posedge clk); #1;
        bus.start   = 1'b0;
    endtask

    task automatic send(input logic signed [DW-1:0] x, input int gap);
        int t = 0;
        for (int g = 0; g < gap; g++) @(posedge clk);
        #1;
        bus.s_valid = 1'b1;
        bus.s_data  = x;
        @(negedge clk);
        while (!bus.s_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.s_ready) fail_now("send_timeout");
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic feed(input int n, input int maxgap, input int poke_at, input logic use_max);
        for (int i = 0; i < n; i++) begin
            if (i == poke_at) begin
                @(posedge clk); #1;
                bus.coef_in = COEF_ALT;
                bus.start   = 1'b1;
                @(posedge clk); #1;
                bus.start   = 1'b0;
                bus.coef_in = COEF_STD;
            end
            send(use_max ? MAXS : pat[i % BL], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
        end
    endtask

    task automatic drain(input int stall, input string name);
        int t = 0, cnt = 0, d0;
        d0 = n_done;
        bus.r_ready = (stall == 0);
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge clk); #1;
            t++;
            if (stall > 0) begin
                if (bus.r_valid && !bus.r_ready) begin
                    cnt++;
                    if (cnt >= stall) bus.r_ready = 1'b1;
                end else begin
                    bus.r_ready = 1'b0;
                    cnt = 0;
                end
            end
        end
        if (exp_q.size() != 0) begin
            fail_now({name, "_results"});
            exp_q.delete();
        end
        t = 0;
        while (n_done == d0 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        bus.r_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_done_pulses"}, n_done - d0, 1);
        chk({name, "_busy"}, bus.busy, 0);
    endtask

    initial begin
        bus.start = 1'b0; bus.coef_in = '0; bus.s_valid = 1'b0;
        bus.s_data = '0;  bus.r_ready = 1'b0;
        #22;
        chk("rst_busy", bus.busy, 0);
        chk("rst_s_ready", bus.s_ready, 0);
        chk("rst_r_valid", bus.r_valid, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_sat", bus.sat_flag, 0);
        chk("rst_r_power", bus.r_power, 0);
        rst = 1'b1;

        // Basic block plus first-result latency
        do_start(COEF_STD);
        chk("accum_s_ready", bus.s_ready, 1);
        push_std();
        feed(BL, 0, -1, 1'b0);
        chk("lat_calc", bus.r_valid, 0);
        @(posedge clk); #1;
        chk("lat_first", bus.r_valid, 1);
        drain(0, "basic");

        // Random input gaps
        do_start(COEF_STD);
        push_std();
        feed(BL, 3, -1, 1'b0);
        drain(0, "gaps");

        // Back-pressure on results
        do_start(COEF_STD);
        push_std();
        feed(BL, 0, -1, 1'b0);
        drain(10, "stall");

        // start during ACCUM with other coefficients is ignored
        do_start(COEF_STD);
        push_std();
        feed(BL, 0, 3, 1'b0);
        drain(0, "ign_start");

        // Saturation
        do_start(COEF_SAT);
        exp_q.push_back('{bin: 1'b0, pwr: P_SAT, last: 1'b0});
        exp_q.push_back('{bin: 1'b1, pwr: P_SAT, last: 1'b1});
        feed(BL, 0, -1, 1'b1);
        drain(0, "sat");
        chk("sat_flag_set", bus.sat_flag, 1);
        do_start(COEF_SAT);
        chk("sat_flag_cleared", bus.sat_flag, 0);

        // Async reset mid-block
        feed(4, 0, -1, 1'b1);
        chk("sat_flag_mid", bus.sat_flag, 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_s_ready", bus.s_ready, 0);
        chk("arst_r_valid", bus.r_valid, 0);
        chk("arst_r_last", bus.r_last, 0);
        chk("arst_sat", bus.sat_flag, 0);
        chk("arst_r_power", bus.r_power, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", bus.busy, 0);
        do_start(COEF_STD);
        push_std();
        feed(BL, 0, -1, 1'b0);
        drain(0, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
